// File: rtl/layer_pkg.sv
// Shared definitions for the layer partial-sum accumulator: FSM encoding and
// elaboration-time width helpers.
package layer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2,
        ST_OUT    = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/psum_requant.sv
// One output channel of requantisation: bias add, arithmetic right shift,
// optional ReLU, then saturation to a signed BITS-wide activation.
module psum_requant
    import layer_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int ACC_W   = 43,
    parameter int BIAS_W  = 32,
    parameter int SHIFT_W = 5
) (
    input  logic [ACC_W-1:0]   acc_in,
    input  logic [BIAS_W-1:0]  bias_in,
    input  logic [SHIFT_W-1:0] shift_amt,
    input  logic               relu_en,
    output logic [BITS-1:0]    res_out,
    output logic               sat_out
);

    // One guard bit above the widest operand keeps the bias add exact.
    localparam int SUM_W = max2(max2(ACC_W, BIAS_W), BITS) + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-BITS+1){1'b1}}, {(BITS-1){1'b0}}};

    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] bias_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;
    logic signed [SUM_W-1:0] relu_v;

    assign acc_ext  = {{(SUM_W-ACC_W){acc_in[ACC_W-1]}}, acc_in};
    assign bias_ext = {{(SUM_W-BIAS_W){bias_in[BIAS_W-1]}}, bias_in};
    assign sum      = acc_ext + bias_ext;
    assign shifted  = sum >>> shift_amt;
    assign relu_v   = (relu_en && shifted[SUM_W-1]) ? '0 : shifted;

    // ReLU runs first, so a zeroed negative never registers as a clip.
    always_comb begin
        res_out = relu_v[BITS-1:0];
        sat_out = 1'b0;
        if (relu_v > SAT_MAX) begin
            res_out = {1'b0, {(BITS-1){1'b1}}};
            sat_out = 1'b1;
        end else if (relu_v < SAT_MIN) begin
            res_out = {1'b1, {(BITS-1){1'b0}}};
            sat_out = 1'b1;
        end
    end

endmodule

// File: rtl/layer_psum_accum.sv
// Accumulates GROUPS partial-sum beats per output channel, then requantises
// all channels in one FINISH cycle and presents the result with a valid/ready handshake.
module layer_psum_accum
    import layer_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int PSUM_W  = 40,
    parameter int BIAS_W  = 32,
    parameter int CH_OUT  = 32,
    parameter int GROUPS  = 4,
    parameter int SHIFT_W = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [CH_OUT*PSUM_W-1:0] psum_in,
    input  logic                     psum_valid,
    output logic                     psum_ready,
    input  logic [CH_OUT*BIAS_W-1:0] bias_in,
    input  logic [SHIFT_W-1:0]       shift_amt,
    input  logic                     relu_en,
    output logic [CH_OUT*BITS-1:0]   data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_any,
    output logic                     busy
);

    // Sized so GROUPS full-scale beats of either sign can never wrap.
    localparam int ACC_W = PSUM_W + clog2(GROUPS) + 1;
    localparam int CNT_W = clog2(GROUPS + 1);

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [CH_OUT-1:0][ACC_W-1:0]  acc_q, acc_d;
    logic [CH_OUT-1:0][BITS-1:0]   data_q, data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          sat_any_q, sat_any_d;

    logic [CH_OUT-1:0][ACC_W-1:0]  psum_ext;
    logic [CH_OUT-1:0][BITS-1:0]   req_res;
    logic [CH_OUT-1:0]             req_sat;

    genvar n;
    generate
        for (n = 0; n < CH_OUT; n++) begin : g_ch
            assign psum_ext[n] = {{(ACC_W-PSUM_W){psum_in[n*PSUM_W+PSUM_W-1]}},
                                  psum_in[n*PSUM_W +: PSUM_W]};

            psum_requant #(
                .BITS    (BITS),
                .ACC_W   (ACC_W),
                .BIAS_W  (BIAS_W),
                .SHIFT_W (SHIFT_W)
            ) u_requant (
                .acc_in    (acc_q[n]),
                .bias_in   (bias_in[n*BIAS_W +: BIAS_W]),
                .shift_amt (shift_amt),
                .relu_en   (relu_en),
                .res_out   (req_res[n]),
                .sat_out   (req_sat[n])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        sat_any_d   = sat_any_q;
        psum_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                psum_ready = 1'b1;
                // First beat overwrites the accumulator so no stale frame leaks in.
                if (psum_valid) begin
                    acc_d   = psum_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = (GROUPS == 1) ? ST_FINISH : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                psum_ready = 1'b1;
                if (psum_valid) begin
                    for (int c = 0; c < CH_OUT; c++) begin
                        acc_d[c] = acc_q[c] + psum_ext[c];
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(GROUPS)) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                data_d      = req_res;
                sat_any_d   = |req_sat;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            sat_any_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            sat_any_q   <= sat_any_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = out_valid_q;
    assign sat_any   = sat_any_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_layer_psum_accum.sv
// Directed bench for layer_psum_accum: a GROUPS=4 build driven frame by frame
// and a GROUPS=1 build streaming back-to-back, both checked against a scoreboard.
module tb_layer_psum_accum;

    localparam int BITS = 16, PSUM_W = 40, BIAS_W = 32, CH = 4, GROUPS = 4, SHIFT_W = 5;
    localparam int G1_CH = 2;

    typedef struct {
        logic [63:0] data;
        logic        sat;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [CH*PSUM_W-1:0] psum_in    = '0;
    logic                 psum_valid = 1'b0;
    logic                 psum_ready;
    logic [CH*BIAS_W-1:0] bias_in    = '0;
    logic [SHIFT_W-1:0]   shift_amt  = '0;
    logic                 relu_en    = 1'b0;
    logic [CH*BITS-1:0]   data_out;
    logic                 out_valid;
    logic                 out_ready  = 1'b0;
    logic                 sat_any;
    logic                 busy;

    logic [G1_CH*PSUM_W-1:0] g1_psum_in   = '0;
    logic                    g1_valid     = 1'b0;
    logic                    g1_ready;
    logic [G1_CH*BIAS_W-1:0] g1_bias_in   = '0;
    logic [SHIFT_W-1:0]      g1_shift     = '0;
    logic                    g1_relu      = 1'b0;
    logic [G1_CH*BITS-1:0]   g1_data_out;
    logic                    g1_out_valid;
    logic                    g1_out_ready = 1'b0;
    logic                    g1_sat_any;
    logic                    g1_busy;

    layer_psum_accum #(
        .BITS(BITS), .PSUM_W(PSUM_W), .BIAS_W(BIAS_W),
        .CH_OUT(CH), .GROUPS(GROUPS), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
        .psum_ready(psum_ready), .bias_in(bias_in), .shift_amt(shift_amt),
        .relu_en(relu_en), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .sat_any(sat_any), .busy(busy)
    );

    layer_psum_accum #(
        .BITS(BITS), .PSUM_W(PSUM_W), .BIAS_W(BIAS_W),
        .CH_OUT(G1_CH), .GROUPS(1), .SHIFT_W(SHIFT_W)
    ) dut_g1 (
        .clk_in(clk_in), .rst_n(rst_n), .psum_in(g1_psum_in), .psum_valid(g1_valid),
        .psum_ready(g1_ready), .bias_in(g1_bias_in), .shift_amt(g1_shift),
        .relu_en(g1_relu), .data_out(g1_data_out), .out_valid(g1_out_valid),
        .out_ready(g1_out_ready), .sat_any(g1_sat_any), .busy(g1_busy)
    );

    int          tests = 0;
    int          fails = 0;
    exp_t        sb_q[$];
    logic [31:0] g1_q[$];
    longint      fb[4][CH];
    longint      bias_v[CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input longint sum, input int sh, input bit relu,
                                          output bit sat);
        longint r;
        r   = sum >>> sh;
        sat = 1'b0;
        if (relu && r < 0) r = 0;
        if (r > 32767) begin
            r   = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1'b1;
        end
        return r[15:0];
    endfunction

    task automatic set_ch(input int c, input longint v0, input longint v1,
                          input longint v2, input longint v3);
        fb[0][c] = v0; fb[1][c] = v1; fb[2][c] = v2; fb[3][c] = v3;
    endtask

    task automatic push_frame();
        exp_t   e;
        longint s;
        bit     st;
        e.data = '0;
        e.sat  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            s = bias_v[c];
            for (int b = 0; b < GROUPS; b++) s += fb[b][c];
            e.data[c*BITS +: BITS] = model(s, int'(shift_amt), relu_en, st);
            e.sat |= st;
            bias_in[c*BIAS_W +: BIAS_W] = bias_v[c][BIAS_W-1:0];
        end
        sb_q.push_back(e);
    endtask

    task automatic set_beat(input int b);
        psum_valid = 1'b1;
        for (int c = 0; c < CH; c++) psum_in[c*PSUM_W +: PSUM_W] = fb[b][c][PSUM_W-1:0];
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive_beat(input int b);
        int n;
        set_beat(b);
        n = 0;
        while (!psum_ready && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk("beat_accept_timeout", 64'(n < 50), 64'd1);
        @(negedge clk_in);
    endtask

    task automatic collect(input string tag, output int lat);
        exp_t e;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
        chk({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        e.data = '0;
        e.sat  = 1'b0;
        if (sb_q.size() != 0) e = sb_q.pop_front();
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, data_out, e.data);
        chk({tag, "_sat"}, 64'(sat_any), 64'(e.sat));
        out_ready = 1'b1;
        @(negedge clk_in);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_data_hold"}, data_out, e.data);
    endtask

    task automatic send_frame(input string tag, input bit check_lat);
        int lat;
        push_frame();
        for (int b = 0; b < GROUPS; b++) drive_beat(b);
        psum_valid = 1'b0;
        collect(tag, lat);
        if (check_lat) chk({tag, "_latency"}, 64'(lat), 64'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int          lat, k, last, nres;
        logic [31:0] g1e;

        // Reset state
        #1;
        chk("rst_data", data_out, 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sat", 64'(sat_any), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(psum_ready), 64'd1);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Frame A: plain accumulate + shift, checks two-cycle latency
        set_ch(0, 100, 200, 300, 400);
        set_ch(1, -160, -160, -160, -160);
        set_ch(2, 0, 0, 0, 0);
        set_ch(3, 5, 5, 5, 5);
        bias_v = '{0, 0, 0, 7};
        shift_amt = 5'd4;
        relu_en   = 1'b0;
        send_frame("A", 1'b1);

        // Frame B: ReLU on, with idle gaps between beats
        relu_en = 1'b1;
        bias_v  = '{0, 0, 0, -100};
        push_frame();
        drive_beat(0);
        drive_beat(1);
        psum_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("B_gap_busy", 64'(busy), 64'd1);
        chk("B_gap_ready", 64'(psum_ready), 64'd1);
        drive_beat(2);
        drive_beat(3);
        psum_valid = 1'b0;
        collect("B", lat);
        chk("B_latency", 64'(lat), 64'd2);

        // Frames C1/C2: positive and negative saturation
        relu_en   = 1'b0;
        shift_amt = 5'd0;
        bias_v    = '{0, 0, 0, 0};
        set_ch(2, 64'sd1073741824, 64'sd1073741824, 64'sd1073741824, 64'sd1073741824);
        send_frame("C1", 1'b1);
        set_ch(0, 1, 2, 3, 4);
        set_ch(1, -1, -2, -3, -4);
        set_ch(2, -64'sd1073741824, -64'sd1073741824, -64'sd1073741824, -64'sd1073741824);
        send_frame("C2", 1'b0);

        // Frame D: values landing exactly on the representable limits
        set_ch(0, 8191, 8192, 8192, 8192);
        set_ch(1, -8192, -8192, -8192, -8192);
        set_ch(2, 0, 0, 0, 0);
        set_ch(3, 0, 0, 0, 0);
        send_frame("D", 1'b0);

        // Frame E: shift truncates toward negative infinity, negative bias
        shift_amt = 5'd1;
        set_ch(0, 1, 1, 1, 0);
        set_ch(1, 0, 0, 0, 0);
        set_ch(3, -1, -1, -1, -2);
        bias_v = '{0, -9, 0, 0};
        send_frame("E", 1'b0);

        // Frame F held by out_ready=0 while frame G's first beat waits
        shift_amt = 5'd2;
        bias_v    = '{0, 0, 0, 0};
        set_ch(0, 40, 40, 40, 40);
        set_ch(1, -40, -40, -40, -40);
        set_ch(2, 1000, 0, 0, 0);
        set_ch(3, 3, 3, 3, 3);
        push_frame();
        for (int b = 0; b < GROUPS; b++) drive_beat(b);
        psum_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
        chk("F_sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        e.data = '0;
        e.sat  = 1'b0;
        if (sb_q.size() != 0) e = sb_q.pop_front();
        chk("F_data", data_out, e.data);
        set_ch(0, 7, 8, 9, 10);
        set_ch(1, -7, -8, -9, -10);
        set_ch(2, 400, 400, 400, 400);
        set_ch(3, 0, 0, 0, 1);
        push_frame();
        set_beat(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("F_stall_ready", 64'(psum_ready), 64'd0);
            chk("F_stall_valid", 64'(out_valid), 64'd1);
            chk("F_stall_data", data_out, e.data);
        end
        out_ready = 1'b1;
        @(negedge clk_in);
        out_ready = 1'b0;
        chk("F_after_hs_valid", 64'(out_valid), 64'd0);
        chk("F_after_hs_ready", 64'(psum_ready), 64'd1);
        @(negedge clk_in);
        chk("G_held_beat_taken", 64'(busy), 64'd1);
        for (int b = 1; b < GROUPS; b++) drive_beat(b);
        psum_valid = 1'b0;
        collect("G", lat);
        chk("G_latency", 64'(lat), 64'd2);

        // Reset mid-frame: partial sums must not leak into the next frame
        set_ch(0, 5000, 5000, 0, 0);
        set_ch(1, 5000, 5000, 0, 0);
        set_ch(2, 5000, 5000, 0, 0);
        set_ch(3, 5000, 5000, 0, 0);
        drive_beat(0);
        drive_beat(1);
        psum_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sat", 64'(sat_any), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        shift_amt = 5'd0;
        for (int c = 0; c < CH; c++) set_ch(c, 10, 10, 10, 10);
        send_frame("R", 1'b1);

        // GROUPS=1 build: one result every three cycles
        g1_out_ready = 1'b1;
        k = 0;
        last = -1;
        nres = 0;
        for (int cy = 0; cy < 21; cy++) begin
            @(negedge clk_in);
            if (g1_out_valid) begin
                chk("g1_sb_nonempty", 64'(g1_q.size() != 0), 64'd1);
                g1e = '0;
                if (g1_q.size() != 0) g1e = g1_q.pop_front();
                chk("g1_data", 64'(g1_data_out), 64'(g1e));
                chk("g1_sat", 64'(g1_sat_any), 64'd0);
                if (last >= 0) chk("g1_interval", 64'(cy - last), 64'd3);
                last = cy;
                nres++;
            end
            if (g1_ready) begin
                if (cy < 18) begin
                    g1_valid = 1'b1;
                    g1_psum_in[0 +: PSUM_W]      = PSUM_W'(100 * k - 250);
                    g1_psum_in[PSUM_W +: PSUM_W] = PSUM_W'(-(3 * k) - 1);
                    g1e = {16'(-(3 * k) - 1), 16'(100 * k - 250)};
                    g1_q.push_back(g1e);
                    k++;
                end else begin
                    g1_valid = 1'b0;
                end
            end
        end
        g1_valid     = 1'b0;
        g1_out_ready = 1'b0;
        chk("g1_result_count", 64'(nres), 64'd6);
        chk("g1_sb_drained", 64'(g1_q.size()), 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer_psum_accum.md
LAYER_PSUM_ACCUM -- requirements
Module: layer_psum_accum

Interface
REQ-001 SHALL have parameter BITS, default 16: signed width of each output activation.
REQ-002 SHALL have parameter PSUM_W, default 40: signed width of each incoming partial sum.
REQ-003 SHALL have parameter BIAS_W, default 32: signed width of each bias word.
REQ-004 SHALL have parameter CH_OUT, default 32: number of output channels processed in parallel.
REQ-005 SHALL have parameter GROUPS, default 4, minimum 1: number of partial-sum beats per result.
REQ-006 SHALL have parameter SHIFT_W, default 5: width of the requantisation shift amount.
REQ-007 SHALL have port clk_in  in  1  single clock, rising edge.
REQ-008 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port psum_in  in  CH_OUT*PSUM_W  partial sums, channel n at bits [n*PSUM_W +: PSUM_W].
REQ-010 SHALL have port psum_valid  in  1  psum_in is valid this cycle.
REQ-011 SHALL have port psum_ready  out  1  block accepts a beat this cycle.
REQ-012 SHALL have port bias_in  in  CH_OUT*BIAS_W  per-channel bias; must stay stable from the first beat to out_valid.
REQ-013 SHALL have port shift_amt  in  SHIFT_W  arithmetic right-shift applied after bias addition.
REQ-014 SHALL have port relu_en  in  1  1 clamps negative results to 0.
REQ-015 SHALL have port data_out  out  CH_OUT*BITS  results, channel n at bits [n*BITS +: BITS].
REQ-016 SHALL have port out_valid  out  1  data_out and sat_any are valid.
REQ-017 SHALL have port out_ready  in  1  downstream accepts the result.
REQ-018 SHALL have port sat_any  out  1  at least one channel saturated in the current result.
REQ-019 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, ACCUM, FINISH and OUT.
REQ-021 SHALL drive psum_ready=1 in IDLE and ACCUM and psum_ready=0 in FINISH and OUT.
REQ-022 SHALL define a beat as accepted when psum_valid and psum_ready are both high.
REQ-023 SHALL, for a beat accepted in IDLE, load the accumulator with the sign-extended psum_in, without adding any stale value.
REQ-024 SHALL, for the same IDLE beat, set the beat counter to 1 and go to ACCUM; when GROUPS=1 it SHALL go to FINISH instead.
REQ-025 SHALL, for a beat accepted in ACCUM, add psum_in to the accumulator and increment the beat counter.
REQ-026 SHALL, for the GROUPS-th beat accepted in ACCUM, go to FINISH.
REQ-027 SHALL hold state and accumulator in ACCUM while psum_valid=0; gaps between beats are allowed.
REQ-028 SHALL size the accumulator at PSUM_W+clog2(GROUPS)+1 bits so it never wraps.
REQ-029 SHALL, in FINISH, compute per channel r = (acc + sign-extended bias) >>> shift_amt, using an arithmetic shift that truncates toward negative infinity.
REQ-030 SHALL, also in FINISH, force r to 0 when relu_en=1 and r<0.
REQ-031 SHALL, also in FINISH, saturate r to [-2^(BITS-1), 2^(BITS-1)-1].
REQ-032 SHALL register r into data_out and go to OUT; shift_amt and relu_en are sampled in FINISH only.
REQ-033 SHALL set sat_any when any channel clipped in the saturation step; a ReLU zeroing SHALL NOT count as saturation.
REQ-034 SHALL assert out_valid throughout OUT and hold data_out and sat_any stable until the out_ready handshake.
REQ-035 SHALL, in OUT with out_ready=1, deassert out_valid next cycle and go to IDLE.
REQ-036 SHALL produce out_valid exactly 2 cycles after the clock edge that accepted the last beat.
REQ-037 SHALL give a minimum initiation interval of GROUPS+2 cycles; beats presented in FINISH or OUT are not consumed and must be held by the source.
REQ-038 SHALL leave data_out unchanged after the handshake until the next FINISH.

Reset
REQ-039 SHALL, while rst_n=0, set state=IDLE and clear the beat counter, accumulators, data_out, out_valid and sat_any to 0, regardless of clock.
REQ-040 SHALL, on reset mid-frame, discard any partial accumulation; the first beat after reset release starts a new frame.

Structure
REQ-041 SHALL place the state encoding and a clog2 helper function in the shared package layer_pkg.
REQ-042 SHALL instantiate one per-channel sub-module psum_requant (bias add, shift, ReLU, saturate) CH_OUT times via generate.

Verification
REQ-043 SHALL cover: GROUPS=4, BITS=16, shift=4, relu=0; ch0 beats 100,200,300,400, bias 0 -> data_out ch0=62 (1000>>>4), out_valid 2 cycles after the 4th beat.
REQ-044 SHALL cover: ch1 beats -160 x4, bias 0, shift 4 -> -40 with relu=0, and 0 with relu=1 and sat_any=0.
REQ-045 SHALL cover: ch2 beats 2^30 x4, bias 0, shift 0 -> 32767, sat_any=1; beats -(2^30) x4 -> -32768.
REQ-046 SHALL cover: out_ready held 0 for 5 cycles -> psum_ready=0 and data_out stable throughout; a held psum_valid beat is accepted the cycle after the handshake.
REQ-047 SHALL cover: rst_n pulsed after the 2nd beat -> all outputs 0; 4 new beats of 10, shift 0 -> 40, with no residue from the earlier frame.
REQ-048 SHALL cover: GROUPS=1 build, back-to-back beats with out_ready=1 -> one result every 3 cycles.
